// File: rtl/mem_bus_ctrl.sv
// Data-side bus controller: posts core stores into a FIFO write buffer drained over a
// req/ack port, forwards loads from the buffer, and stalls the core on load misses.
module mem_bus_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [31:0]              ALUResult,
  input  logic [31:0]              WriteData,
  output logic [31:0]              ReadData,
  output logic                     Stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;

  state_t             r_state;
  logic [29:0]        r_buf_addr [DEPTH];
  logic [31:0]        r_buf_data [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [29:0]        r_rd_addr;
  logic [31:0]        r_rdata;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_ld;
  logic [29:0]        w_ld_addr;
  logic               w_hit;
  logic [31:0]        w_hit_data;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_unused_lo;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_push      = MemWrite & ~w_full;
  assign w_pop       = (r_state == WR) & mem_ack;
  assign w_ld        = MemRead & ~MemWrite;
  assign w_ld_addr   = ALUResult[31:2];
  assign w_unused_lo = ^ALUResult[1:0];

  // Scan oldest to newest so the last match seen is the newest store to that word.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_buf_addr[r_head + PTR_W'(i)] == w_ld_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_buf_data[r_head + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CNT_W'(1);
  end

  always_comb begin
    Stall    = 1'b0;
    ReadData = '0;
    if (MemWrite) begin
      Stall = w_full;
    end else if (MemRead) begin
      if (r_state == RD_DONE)
        ReadData = r_rdata;
      else if (w_hit)
        ReadData = w_hit_data;
      else
        Stall = 1'b1;
    end
  end

  // Memory port is a pure function of registered state, never of core inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_buf_addr[r_head], 2'b00};
        mem_wdata = r_buf_data[r_head];
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = {r_rd_addr, 2'b00};
      end
      default: ;
    endcase
  end

  assign count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_addr[r_tail] <= ALUResult[31:2];
      r_buf_data[r_tail] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PTR_W'(1);
      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      r_count <= w_count_nxt;
      case (r_state)
        IDLE: begin
          // A read may only go out once every buffered store has drained.
          if (w_ld && !w_hit && (r_count == '0)) begin
            r_state   <= RD;
            r_rd_addr <= w_ld_addr;
          end else if (r_count != '0) begin
            r_state <= WR;
          end
        end
        WR: begin
          if (w_pop && (w_count_nxt == '0))
            r_state <= IDLE;
        end
        RD: begin
          if (mem_ack) begin
            r_rdata <= mem_rdata;
            r_state <= RD_DONE;
          end
        end
        RD_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
